// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer
//   Fetch/decode control sequencer for the one-cycle 8-bit datapath. It
//   holds the program counter, fetches one instruction per pass from the
//   program ROM, and decodes it into register-file and ALU controls.
//   Branch, jump and halt are resolved here.
//
//   Instruction: [7:6] op, [5:4] rd, [3:2] rs1, [1:0] rs2
//     00 ADD, 01 SUB, 10 LDI, 11 control (rd = 00 NOP, 01 HALT, 10 JMP, 11 BZ)
//
//   Optional feature: define CTRL_STEP_EN to add the `step` input and a
//   WAIT state, which pauses after each executed instruction.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   step                (CTRL_STEP_EN only) release from WAIT
//   start               leave IDLE/HALT and begin fetching
//   instr_data[7:0]     ROM word at address pc (combinational)
//   alu_zero            ALU result is zero, valid in EXEC
//   pc[PC_W-1:0]        program counter
//   read_addr1/2[1:0]   register-file read addresses
//   write_addr[1:0]     register-file write address
//   write_enable        register-file write strobe (EXEC only)
//   alu_op              0 = add, 1 = subtract
//   wb_sel              0 = ALU result, 1 = imm
//   imm[7:0]            zero-extended 4-bit immediate
//   halted              high while in HALT
module ctrl_sequencer #(
    parameter int PC_W = 4
) (
    input  logic            clk,
    input  logic            reset_n,
`ifdef CTRL_STEP_EN
    input  logic            step,
`endif
    input  logic            start,
    input  logic [7:0]      instr_data,
    input  logic            alu_zero,
    output logic [PC_W-1:0] pc,
    output logic [1:0]      read_addr1,
    output logic [1:0]      read_addr2,
    output logic [1:0]      write_addr,
    output logic            write_enable,
    output logic            alu_op,
    output logic            wb_sel,
    output logic [7:0]      imm,
    output logic            halted
);

`ifdef CTRL_STEP_EN
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT, S_WAIT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;
`endif

    state_t          state;
    logic [7:0]      ir;
    logic            z_flag;

    logic [1:0]      op;
    logic [1:0]      sub_op;
    logic            is_alu;
    logic            is_halt;
    logic            take_target;
    logic [PC_W-1:0] target;

    assign op     = ir[7:6];
    assign sub_op = ir[5:4];
    assign is_alu = (op == 2'b00) || (op == 2'b01);
    assign is_halt = (op == 2'b11) && (sub_op == 2'b01);
    // BZ looks only at the committed flag, never the live alu_zero.
    assign take_target = (op == 2'b11) &&
                         ((sub_op == 2'b10) || ((sub_op == 2'b11) && z_flag));
    assign target = PC_W'(ir[3:0]);

    // Decode is purely a function of IR and state, so an asynchronous
    // reset clears every control output at once.
    assign read_addr1   = ir[3:2];
    assign read_addr2   = ir[1:0];
    assign write_addr   = ir[5:4];
    assign alu_op       = ir[6];
    assign wb_sel       = (op == 2'b10);
    assign imm          = {4'b0000, ir[3:0]};
    assign write_enable = (state == S_EXEC) && (op != 2'b11);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            ir     <= 8'h00;
            pc     <= '0;
            z_flag <= 1'b0;
            halted <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) state <= S_FETCH;
                end
                S_FETCH: begin
                    ir    <= instr_data;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (is_alu) z_flag <= alu_zero;
                    // HALT also advances pc; it is then frozen in HALT.
                    if (take_target) pc <= target;
                    else             pc <= pc + PC_W'(1);
                    if (is_halt) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
`ifdef CTRL_STEP_EN
                        state <= S_WAIT;
`else
                        state <= S_FETCH;
`endif
                    end
                end
                S_HALT: begin
                    if (start) begin
                        pc     <= '0;
                        z_flag <= 1'b0;
                        halted <= 1'b0;
                        state  <= S_FETCH;
                    end
                end
`ifdef CTRL_STEP_EN
                S_WAIT: begin
                    if (step) state <= S_FETCH;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer (PC_W = 4). A cycle-by-cycle vector
// table walks a small program through LDI, ADD, taken/untaken BZ, JMP,
// pc wrap, HALT and restart; hand-written sequences cover reset in EXEC
// and, when CTRL_STEP_EN is defined, single stepping.
module tb_ctrl_sequencer;

    logic       clk;
    logic       reset_n;
    logic       step;
    logic       start;
    logic [7:0] instr_data;
    logic       alu_zero;
    logic [3:0] pc;
    logic [1:0] read_addr1, read_addr2, write_addr;
    logic       write_enable, alu_op, wb_sel, halted;
    logic [7:0] imm;

    logic [7:0] rom [16];
    int checks = 0;
    int errors = 0;

    assign instr_data = rom[pc];

    ctrl_sequencer #(.PC_W(4)) dut (
        .clk(clk),
        .reset_n(reset_n),
`ifdef CTRL_STEP_EN
        .step(step),
`endif
        .start(start),
        .instr_data(instr_data),
        .alu_zero(alu_zero),
        .pc(pc),
        .read_addr1(read_addr1),
        .read_addr2(read_addr2),
        .write_addr(write_addr),
        .write_enable(write_enable),
        .alu_op(alu_op),
        .wb_sel(wb_sel),
        .imm(imm),
        .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic       start;
        logic       az;
        logic [3:0] pc;
        logic       we;
        logic [1:0] wa, ra1, ra2;
        logic       aop, wb;
        logic [7:0] imm;
        logic       hlt;
    } vec_t;

    vec_t tv [25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] pack_out(input logic [3:0] p, input logic we,
        input logic [1:0] wa, input logic [1:0] r1, input logic [1:0] r2,
        input logic aop, input logic wb, input logic [7:0] im, input logic h);
        return {9'b0, p, we, wa, r1, r2, aop, wb, im, h};
    endfunction

    logic [31:0] act_v, exp_v;
    logic        prev_we;

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 8'hC0;  // NOP
        rom[0]  = 8'h97;  // LDI r1, 7
        rom[1]  = 8'h06;  // ADD r0 = r1 + r2
        rom[2]  = 8'hF5;  // BZ 5
        rom[3]  = 8'hD0;  // HALT
        rom[5]  = 8'hEA;  // JMP 10
        rom[10] = 8'hEF;  // JMP 15
        rom[15] = 8'h06;  // ADD

        //        start az  pc     we  wa  ra1 ra2 aop wb  imm    hlt
        tv[0]  = '{1'b1,1'b0,4'h0,1'b0,2'd0,2'd0,2'd0,1'b0,1'b0,8'h00,1'b0}; // IDLE
        tv[1]  = '{1'b0,1'b0,4'h0,1'b0,2'd0,2'd0,2'd0,1'b0,1'b0,8'h00,1'b0}; // FETCH
        tv[2]  = '{1'b0,1'b0,4'h0,1'b1,2'd1,2'd1,2'd3,1'b0,1'b1,8'h07,1'b0}; // EXEC LDI
        tv[3]  = '{1'b1,1'b0,4'h1,1'b0,2'd1,2'd1,2'd3,1'b0,1'b1,8'h07,1'b0}; // start ignored
        tv[4]  = '{1'b1,1'b1,4'h1,1'b1,2'd0,2'd1,2'd2,1'b0,1'b0,8'h06,1'b0}; // ADD, Z<=1
        tv[5]  = '{1'b0,1'b1,4'h2,1'b0,2'd0,2'd1,2'd2,1'b0,1'b0,8'h06,1'b0};
        tv[6]  = '{1'b0,1'b0,4'h2,1'b0,2'd3,2'd1,2'd1,1'b1,1'b0,8'h05,1'b0}; // BZ taken
        tv[7]  = '{1'b0,1'b0,4'h5,1'b0,2'd3,2'd1,2'd1,1'b1,1'b0,8'h05,1'b0};
        tv[8]  = '{1'b0,1'b0,4'h5,1'b0,2'd2,2'd2,2'd2,1'b1,1'b0,8'h0A,1'b0}; // JMP 10
        tv[9]  = '{1'b0,1'b0,4'hA,1'b0,2'd2,2'd2,2'd2,1'b1,1'b0,8'h0A,1'b0};
        tv[10] = '{1'b0,1'b0,4'hA,1'b0,2'd2,2'd3,2'd3,1'b1,1'b0,8'h0F,1'b0}; // JMP 15
        tv[11] = '{1'b0,1'b0,4'hF,1'b0,2'd2,2'd3,2'd3,1'b1,1'b0,8'h0F,1'b0};
        tv[12] = '{1'b0,1'b0,4'hF,1'b1,2'd0,2'd1,2'd2,1'b0,1'b0,8'h06,1'b0}; // ADD, Z<=0
        tv[13] = '{1'b0,1'b0,4'h0,1'b0,2'd0,2'd1,2'd2,1'b0,1'b0,8'h06,1'b0}; // wrapped
        tv[14] = '{1'b0,1'b0,4'h0,1'b1,2'd1,2'd1,2'd3,1'b0,1'b1,8'h07,1'b0};
        tv[15] = '{1'b0,1'b0,4'h1,1'b0,2'd1,2'd1,2'd3,1'b0,1'b1,8'h07,1'b0};
        tv[16] = '{1'b0,1'b0,4'h1,1'b1,2'd0,2'd1,2'd2,1'b0,1'b0,8'h06,1'b0};
        tv[17] = '{1'b0,1'b0,4'h2,1'b0,2'd0,2'd1,2'd2,1'b0,1'b0,8'h06,1'b0};
        tv[18] = '{1'b0,1'b1,4'h2,1'b0,2'd3,2'd1,2'd1,1'b1,1'b0,8'h05,1'b0}; // BZ untaken
        tv[19] = '{1'b0,1'b0,4'h3,1'b0,2'd3,2'd1,2'd1,1'b1,1'b0,8'h05,1'b0};
        tv[20] = '{1'b0,1'b0,4'h3,1'b0,2'd1,2'd0,2'd0,1'b1,1'b0,8'h00,1'b0}; // HALT
        tv[21] = '{1'b0,1'b0,4'h4,1'b0,2'd1,2'd0,2'd0,1'b1,1'b0,8'h00,1'b1};
        tv[22] = '{1'b1,1'b0,4'h4,1'b0,2'd1,2'd0,2'd0,1'b1,1'b0,8'h00,1'b1};
        tv[23] = '{1'b0,1'b0,4'h0,1'b0,2'd1,2'd0,2'd0,1'b1,1'b0,8'h00,1'b0}; // restart
        tv[24] = '{1'b0,1'b0,4'h0,1'b1,2'd1,2'd1,2'd3,1'b0,1'b1,8'h07,1'b0};

        reset_n  = 1'b0;
        start    = 1'b0;
        step     = 1'b0;
        alu_zero = 1'b0;
        #23;
        @(negedge clk);
        reset_n = 1'b1;

`ifdef CTRL_STEP_EN
        // Single-step: pause in WAIT after every instruction.
        start = 1'b1;
        tick();                          // FETCH
        start = 1'b0;
        tick();                          // EXEC LDI
        chk("step_ldi_we", {31'b0, write_enable}, 32'd1);
        tick();                          // WAIT
        chk("step_wait_pc1", {28'b0, pc}, 32'd1);
        step = 1'b1;
        tick();                          // FETCH
        step = 1'b0;
        tick();                          // EXEC ADD
        chk("step_add_we", {31'b0, write_enable}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("step_hold", {27'b0, write_enable, pc}, 32'd2);
        end
        step = 1'b1;
        tick();                          // FETCH BZ
        step = 1'b0;
        tick();                          // EXEC BZ, Z = 0
        chk("step_bz_we", {31'b0, write_enable}, 32'd0);
        tick();
        chk("step_one_instr_pc", {28'b0, pc}, 32'd3);
        tick();
        chk("step_still_wait", {28'b0, pc}, 32'd3);
`else
        prev_we = 1'b0;
        for (int i = 0; i < 25; i++) begin
            start    = tv[i].start;
            alu_zero = tv[i].az;
            #1;
            act_v = pack_out(pc, write_enable, write_addr, read_addr1, read_addr2,
                             alu_op, wb_sel, imm, halted);
            exp_v = pack_out(tv[i].pc, tv[i].we, tv[i].wa, tv[i].ra1, tv[i].ra2,
                             tv[i].aop, tv[i].wb, tv[i].imm, tv[i].hlt);
            chk($sformatf("vec%0d", i), act_v, exp_v);
            chk($sformatf("we_pulse%0d", i), {31'b0, prev_we & write_enable}, 32'd0);
            prev_we = write_enable;
            tick();
        end

        // Reset during EXEC of ADD at pc 1.
        start    = 1'b0;
        alu_zero = 1'b1;
        tick();                          // EXEC ADD
        chk("pre_reset_we", {31'b0, write_enable}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("reset_we_async", {31'b0, write_enable}, 32'd0);
        chk("reset_pc", {28'b0, pc}, 32'd0);
        chk("reset_decode", {22'b0, write_addr, read_addr1, read_addr2, imm[3:0]}, 32'd0);
        chk("reset_halted", {31'b0, halted}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        tick();
        chk("idle_after_reset", {27'b0, write_enable, pc}, 32'd0);

        // First write_enable two cycles after start.
        start = 1'b1;
        tick();                          // FETCH
        start = 1'b0;
        chk("start_fetch_we", {31'b0, write_enable}, 32'd0);
        tick();                          // EXEC LDI
        chk("start_exec", {29'b0, write_enable, write_addr}, 32'h5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Fetch/decode control sequencer for the one-cycle 8-bit datapath, sitting directly upstream of the 4x8 register file. It holds the program counter, fetches one 8-bit instruction per pass from program ROM, decodes it, and drives the register-file read addresses, write address, write enable, ALU opcode and immediate. Branch, jump and halt are handled here; arithmetic happens in the downstream ALU.

## Interface
- `PC_W`, default 4: program counter width; minimum 4.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  leaves IDLE or HALT and begins fetching.
- `instr_data`  in  8  ROM word at address `pc`, combinational from `pc`.
- `alu_zero`  in  1  ALU result equals zero, valid during EXEC.
- `pc`  out  PC_W  current program counter.
- `read_addr1`, `read_addr2`  out  2  register-file read addresses.
- `write_addr`  out  2  register-file write address.
- `write_enable`  out  1  register-file write strobe.
- `alu_op`  out  1  0 = add, 1 = subtract.
- `wb_sel`  out  1  0 = ALU result to register file, 1 = `imm`.
- `imm`  out  8  zero-extended 4-bit immediate.
- `halted`  out  1  high while in HALT.

## Operation
- Instruction format: [7:6] op, [5:4] rd, [3:2] rs1, [1:0] rs2.
  - op 00 ADD: rd = rs1 + rs2.
  - op 01 SUB: rd = rs1 - rs2.
  - op 10 LDI: rd = {4'b0, rs1, rs2}.
  - op 11 control, sub-op = rd field:
    - 00 NOP.
    - 01 HALT.
    - 10 JMP: pc = target.
    - 11 BZ: pc = target if the Z flag is set, else pc + 1.
    - target = {rs1, rs2}, zero-extended to PC_W.
- States: IDLE, FETCH, EXEC, HALT.
  - IDLE: on `start` go to FETCH.
  - FETCH: IR <= `instr_data`; go to EXEC.
  - EXEC: commit the instruction; go to HALT if the instruction is HALT, else FETCH.
  - HALT: on `start` set pc = 0, clear Z, go to FETCH.
- Decode is combinational from IR:
  - `read_addr1` = IR[3:2], `read_addr2` = IR[1:0], `write_addr` = IR[5:4].
  - `alu_op` = IR[6], `wb_sel` = (op == 10), `imm` = {4'b0, IR[3:0]}.
- `write_enable` is high only in EXEC when op is 00, 01 or 10.
- Z flag:
  - Loaded from `alu_zero` at the end of EXEC for ADD and SUB only.
  - LDI and control instructions leave Z unchanged.
- PC update at the end of EXEC: pc + 1 modulo 2^PC_W (2^PC_W - 1 wraps to 0), unless a JMP or taken BZ loads the target.
- pc does not change in FETCH, IDLE or HALT.
- `start` is ignored in FETCH and EXEC.

## Timing
- Reset values: state IDLE; IR, pc, Z, `halted` all 0.
  - All decode outputs therefore reset to 0 as well: addresses 0, `write_enable` 0, `imm` 0, `alu_op` 0, `wb_sel` 0.
- Each instruction takes 2 cycles (FETCH, EXEC).
  - The register file captures the result at the rising edge that ends EXEC.
  - The next FETCH presents the new `pc` to the ROM.
- `write_enable` is a single-cycle pulse per writing instruction, never high in two consecutive cycles.
- From `start` sampled high in IDLE:
  - FETCH is in the next cycle.
  - The first `write_enable` is in the cycle after that (2 cycles after `start`).
- Reset asserted mid-EXEC: `write_enable` drops immediately (asynchronously) and no register write or pc update occurs.
- BZ reads the Z value committed by an earlier instruction; the same-cycle `alu_zero` is never used for the branch decision.

## Configuration
- `CTRL_STEP_EN` defined:
  - Adds input port `step` (1 bit) and a state WAIT.
  - EXEC of a non-HALT instruction goes to WAIT instead of FETCH.
  - WAIT goes to FETCH in the cycle after `step` is sampled high; pc is held in WAIT.
  - Reset from WAIT returns to IDLE.
- `CTRL_STEP_EN` undefined: no `step` port, no WAIT state; execution runs freely as described above.

## Test plan
- Reset then `start`; ROM[0] = 0x97 (LDI r1, 7) -> `write_enable` pulses in EXEC with `write_addr` = 1, `wb_sel` = 1, `imm` = 0x07; pc goes 0 -> 1.
- ROM[1] = 0x06 (ADD r0 = r1 + r2) with `alu_zero` = 1 -> `read_addr1` = 1, `read_addr2` = 2, `alu_op` = 0; Z = 1. Then ROM[2] = 0xF5 (BZ 5) -> pc = 5.
- ROM[2] = 0xF5 with Z = 0 -> pc = 3. ROM[3] = 0xEA (JMP 10) -> pc = 10 and `write_enable` stays 0.
- PC_W = 4, pc = 15 holding ADD -> pc wraps to 0. ROM word 0xD0 (HALT) -> `halted` = 1 and pc frozen; `start` -> pc = 0 and FETCH.
- Assert `reset_n` low during the EXEC of an ADD -> `write_enable` low the same cycle; pc, IR, Z = 0; state IDLE.
- With `CTRL_STEP_EN`: after the first ADD commits, FSM holds in WAIT with pc stable for 10 cycles; one `step` pulse -> exactly one further instruction executes.
